// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares one L2 request port between the L1 I-cache and
// L1 D-cache controllers. One request is latched at a time, held on the L2
// port until L2 completes (or the watchdog expires), then the completion is
// routed back to the requester that owned the grant.
//
// Handshake: req_l1i_arb / req_l1d_arb are levels held by the requester
// until its one-cycle ready_arb_l1x pulse, and dropped during that pulse
// cycle. read_arb_l2 / write_arb_l2 are levels held until L2 returns a
// one-cycle ready_l2_arb pulse. ready_l2_arb is only honoured in a grant
// state; in IDLE or RESP it is ignored.
module l1_l2_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_l1i_arb,
  input  logic [ADDR_W-1:0] addr_l1i_arb,
  input  logic              req_l1d_arb,
  input  logic              we_l1d_arb,
  input  logic [ADDR_W-1:0] addr_l1d_arb,
  input  logic [LINE_W-1:0] wdata_l1d_arb,
  output logic              read_arb_l2,
  output logic              write_arb_l2,
  output logic [ADDR_W-1:0] addr_arb_l2,
  output logic [LINE_W-1:0] wdata_arb_l2,
  input  logic              ready_l2_arb,
  input  logic [LINE_W-1:0] rdata_l2_arb,
  output logic              ready_arb_l1i,
  output logic              ready_arb_l1d,
  output logic [LINE_W-1:0] rdata_arb_l1,
  output logic              busy,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_I = 2'd1;
  localparam logic [1:0] S_GNT_D = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Watchdog value in the last grant cycle before a forced abort: a grant
  // lasts at most TIMEOUT_CYC cycles.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [1:0]        r_state;
  logic              r_last_d;   // 1: last grant went to D, 0: to I
  logic [WD_W-1:0]   r_wd;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_rdy_i;
  logic              r_rdy_d;
  logic [LINE_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_err;

  logic w_grant_i;
  logic w_grant_d;
  logic w_wd_expire;
  logic w_done;

  // Round-robin pick: I wins when alone or when D was granted last.
  assign w_grant_i   = req_l1i_arb & (~req_l1d_arb | r_last_d);
  assign w_grant_d   = req_l1d_arb & ~w_grant_i;
  assign w_wd_expire = (r_wd == WD_LAST);
  assign w_done      = ready_l2_arb | w_wd_expire;

  // FSM, L2 request latching, response routing and watchdog.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b1;
      r_wd     <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdy_i  <= 1'b0;
      r_rdy_d  <= 1'b0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdy_i <= 1'b0;
      r_rdy_d <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (w_grant_i) begin
            r_state  <= S_GNT_I;
            r_read   <= 1'b1;
            r_write  <= 1'b0;
            r_addr   <= addr_l1i_arb;
            r_last_d <= 1'b0;
            r_busy   <= 1'b1;
          end else if (w_grant_d) begin
            r_state  <= S_GNT_D;
            r_read   <= ~we_l1d_arb;
            r_write  <= we_l1d_arb;
            r_addr   <= addr_l1d_arb;
            r_last_d <= 1'b1;
            r_busy   <= 1'b1;
            if (we_l1d_arb) begin
              r_wdata <= wdata_l1d_arb;
            end
          end
        end
        S_GNT_I, S_GNT_D: begin
          if (w_done) begin
            r_state <= S_RESP;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_wd    <= '0;
            r_rdy_i <= (r_state == S_GNT_I);
            r_rdy_d <= (r_state == S_GNT_D);
            // A real completion wins over an expiring watchdog.
            r_rdata <= ready_l2_arb ? rdata_l2_arb : '0;
            if (!ready_l2_arb) begin
              r_err <= 1'b1;
            end
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign read_arb_l2   = r_read;
  assign write_arb_l2  = r_write;
  assign addr_arb_l2   = r_addr;
  assign wdata_arb_l2  = r_wdata;
  assign ready_arb_l1i = r_rdy_i;
  assign ready_arb_l1d = r_rdy_d;
  assign rdata_arb_l1  = r_rdata;
  assign busy          = r_busy;
  assign err_timeout   = r_err;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed testbench for l1_l2_arbiter: reset, single fills, write-back,
// round-robin alternation, watchdog abort and asynchronous reset.
module tb_l1_l2_arbiter;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 128;
  localparam int TO_CYC = 255;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              req_l1i_arb = 1'b0;
  logic [ADDR_W-1:0] addr_l1i_arb = '0;
  logic              req_l1d_arb = 1'b0;
  logic              we_l1d_arb = 1'b0;
  logic [ADDR_W-1:0] addr_l1d_arb = '0;
  logic [LINE_W-1:0] wdata_l1d_arb = '0;
  logic              read_arb_l2;
  logic              write_arb_l2;
  logic [ADDR_W-1:0] addr_arb_l2;
  logic [LINE_W-1:0] wdata_arb_l2;
  logic              ready_l2_arb = 1'b0;
  logic [LINE_W-1:0] rdata_l2_arb = '0;
  logic              ready_arb_l1i;
  logic              ready_arb_l1d;
  logic [LINE_W-1:0] rdata_arb_l1;
  logic              busy;
  logic              err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [LINE_W-1:0] exp_q[$];

  l1_l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .nrst(nrst),
    .req_l1i_arb(req_l1i_arb), .addr_l1i_arb(addr_l1i_arb),
    .req_l1d_arb(req_l1d_arb), .we_l1d_arb(we_l1d_arb),
    .addr_l1d_arb(addr_l1d_arb), .wdata_l1d_arb(wdata_l1d_arb),
    .read_arb_l2(read_arb_l2), .write_arb_l2(write_arb_l2),
    .addr_arb_l2(addr_arb_l2), .wdata_arb_l2(wdata_arb_l2),
    .ready_l2_arb(ready_l2_arb), .rdata_l2_arb(rdata_l2_arb),
    .ready_arb_l1i(ready_arb_l1i), .ready_arb_l1d(ready_arb_l1d),
    .rdata_arb_l1(rdata_arb_l1), .busy(busy), .err_timeout(err_timeout)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "global timeout");
  end

  // Scoreboard comparison point
  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    req_l1i_arb   = 1'b0;
    addr_l1i_arb  = '0;
    req_l1d_arb   = 1'b0;
    we_l1d_arb    = 1'b0;
    addr_l1d_arb  = '0;
    wdata_l1d_arb = '0;
    ready_l2_arb  = 1'b0;
    rdata_l2_arb  = '0;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_l1i_arb   = 1'($urandom_range(0, 1));
      req_l1d_arb   = 1'($urandom_range(0, 1));
      we_l1d_arb    = 1'($urandom_range(0, 1));
      ready_l2_arb  = 1'($urandom_range(0, 1));
      addr_l1i_arb  = {$urandom, $urandom};
      addr_l1d_arb  = {$urandom, $urandom};
      wdata_l1d_arb = {$urandom, $urandom, $urandom, $urandom};
      rdata_l2_arb  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    clear_inputs();
    nrst = 1'b1;
  endtask

  localparam logic [ADDR_W-1:0] A_I1 = 64'h0000_0000_0000_1A40;
  localparam logic [ADDR_W-1:0] A_WB = 64'h0000_0000_0000_2B80;
  localparam logic [ADDR_W-1:0] A_IA = 64'h0000_0000_0000_3C00;
  localparam logic [ADDR_W-1:0] A_DA = 64'h0000_0000_0000_4D10;
  localparam logic [LINE_W-1:0] D_BEEF = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [LINE_W-1:0] D_WB   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [LINE_W-1:0] D_WBR  = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  initial begin
    logic [LINE_W-1:0] exp_addr;
    logic exp_is_i;
    int prev_cyc;
    int n;

    // Reset with random inputs
    apply_reset();
    check("rst_read", read_arb_l2, 0);
    check("rst_write", write_arb_l2, 0);
    check("rst_addr", addr_arb_l2, 0);
    check("rst_wdata", wdata_arb_l2, 0);
    check("rst_rdy", {ready_arb_l1i, ready_arb_l1d}, 0);
    check("rst_rdata", rdata_arb_l1, 0);
    check("rst_busy_err", {busy, err_timeout}, 0);

    // ready_l2_arb while idle is ignored
    tick();
    ready_l2_arb = 1'b1;
    rdata_l2_arb = D_WBR;
    tick();
    ready_l2_arb = 1'b0;
    check("idle_ready_pulse", {ready_arb_l1i, ready_arb_l1d, busy}, 0);
    check("idle_ready_rdata", rdata_arb_l1, 0);

    // Single I fill, L2 ready in the 4th grant cycle
    req_l1i_arb  = 1'b1;
    addr_l1i_arb = A_I1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("ifill_read_c%0d", i), {read_arb_l2, write_arb_l2}, 2'b10);
      check($sformatf("ifill_addr_c%0d", i), addr_arb_l2, A_I1);
      check($sformatf("ifill_rdy_c%0d", i), {ready_arb_l1i, ready_arb_l1d, busy}, 3'b001);
      addr_l1i_arb = 64'hFFFF_0000_FFFF_0000;
    end
    ready_l2_arb = 1'b1;
    rdata_l2_arb = D_BEEF;
    tick();
    ready_l2_arb = 1'b0;
    rdata_l2_arb = '0;
    req_l1i_arb  = 1'b0;
    check("ifill_resp_rdy", {ready_arb_l1i, ready_arb_l1d}, 2'b10);
    check("ifill_resp_rdata", rdata_arb_l1, D_BEEF);
    check("ifill_resp_req", {read_arb_l2, write_arb_l2, busy}, 3'b001);
    tick();
    check("ifill_idle", {ready_arb_l1i, ready_arb_l1d, busy}, 0);

    // D write-back
    req_l1d_arb   = 1'b1;
    we_l1d_arb    = 1'b1;
    addr_l1d_arb  = A_WB;
    wdata_l1d_arb = D_WB;
    tick();
    check("wb_rw", {read_arb_l2, write_arb_l2}, 2'b01);
    check("wb_addr", addr_arb_l2, A_WB);
    check("wb_wdata", wdata_arb_l2, D_WB);
    wdata_l1d_arb = '0;
    tick();
    check("wb_hold", {read_arb_l2, write_arb_l2, busy}, 3'b011);
    check("wb_wdata_hold", wdata_arb_l2, D_WB);
    ready_l2_arb = 1'b1;
    rdata_l2_arb = D_WBR;
    tick();
    ready_l2_arb = 1'b0;
    req_l1d_arb  = 1'b0;
    we_l1d_arb   = 1'b0;
    check("wb_resp_rdy", {ready_arb_l1i, ready_arb_l1d}, 2'b01);
    check("wb_resp_rdata", rdata_arb_l1, D_WBR);
    check("wb_resp_rw", {read_arb_l2, write_arb_l2}, 0);
    tick();
    check("wb_idle", {ready_arb_l1i, ready_arb_l1d, busy}, 0);

    // Simultaneous requests after reset: grants alternate I, D, I, D
    apply_reset();
    exp_q.push_back(LINE_W'(A_IA));
    exp_q.push_back(LINE_W'(A_DA));
    exp_q.push_back(LINE_W'(A_IA));
    exp_q.push_back(LINE_W'(A_DA));
    req_l1i_arb  = 1'b1;
    addr_l1i_arb = A_IA;
    req_l1d_arb  = 1'b1;
    we_l1d_arb   = 1'b0;
    addr_l1d_arb = A_DA;
    prev_cyc = -1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      tick();
      while (!read_arb_l2 && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("alt_req_seen_%0d", g), read_arb_l2, 1);
      exp_addr = exp_q.pop_front();
      exp_is_i = (exp_addr == LINE_W'(A_IA));
      check($sformatf("alt_addr_%0d", g), addr_arb_l2, exp_addr);
      if (prev_cyc >= 0) begin
        check($sformatf("alt_spacing_%0d", g), cyc - prev_cyc, 3);
      end
      prev_cyc = cyc;
      ready_l2_arb = 1'b1;
      rdata_l2_arb = {96'h0, 32'(g + 32'hA0)};
      tick();
      ready_l2_arb = 1'b0;
      check($sformatf("alt_rdy_%0d", g), {ready_arb_l1i, ready_arb_l1d}, {exp_is_i, ~exp_is_i});
      check($sformatf("alt_rdata_%0d", g), rdata_arb_l1, {96'h0, 32'(g + 32'hA0)});
    end
    req_l1i_arb = 1'b0;
    req_l1d_arb = 1'b0;
    tick();
    check("alt_done_idle", {busy, read_arb_l2, write_arb_l2}, 0);

    // Watchdog: D fill with L2 silent
    req_l1d_arb  = 1'b1;
    we_l1d_arb   = 1'b0;
    addr_l1d_arb = A_DA;
    tick();
    check("to_read", {read_arb_l2, write_arb_l2}, 2'b10);
    check("to_err_before", err_timeout, 0);
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (ready_arb_l1d) break;
    end
    check("to_cycles", n, TO_CYC);
    check("to_rdy", {ready_arb_l1i, ready_arb_l1d}, 2'b01);
    check("to_rdata_zero", rdata_arb_l1, 0);
    check("to_err", err_timeout, 1);
    req_l1d_arb = 1'b0;
    tick();
    check("to_idle", {busy, ready_arb_l1d}, 0);

    // Successful fill after the abort keeps err_timeout sticky
    req_l1i_arb  = 1'b1;
    addr_l1i_arb = A_I1;
    tick();
    ready_l2_arb = 1'b1;
    rdata_l2_arb = D_BEEF;
    tick();
    ready_l2_arb = 1'b0;
    req_l1i_arb  = 1'b0;
    check("sticky_rdy", {ready_arb_l1i, ready_arb_l1d}, 2'b10);
    check("sticky_rdata", rdata_arb_l1, D_BEEF);
    check("sticky_err", err_timeout, 1);
    tick();

    // Asynchronous reset while in GNT_D
    req_l1d_arb   = 1'b1;
    we_l1d_arb    = 1'b1;
    addr_l1d_arb  = A_WB;
    wdata_l1d_arb = D_WB;
    tick();
    check("mid_write", write_arb_l2, 1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_rw", {read_arb_l2, write_arb_l2, busy, err_timeout}, 0);
    check("mid_rst_addr", addr_arb_l2, 0);
    check("mid_rst_wdata", wdata_arb_l2, 0);
    check("mid_rst_rdata", rdata_arb_l1, 0);
    clear_inputs();
    req_l1i_arb  = 1'b1;
    addr_l1i_arb = A_IA;
    tick();
    nrst = 1'b1;
    tick();
    check("post_rst_grant", {read_arb_l2, write_arb_l2}, 2'b10);
    check("post_rst_addr", addr_arb_l2, A_IA);
    ready_l2_arb = 1'b1;
    rdata_l2_arb = D_WBR;
    tick();
    ready_l2_arb = 1'b0;
    req_l1i_arb  = 1'b0;
    check("post_rst_rdy", {ready_arb_l1i, ready_arb_l1d}, 2'b10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
